// File: rtl/gpio_ctrl_apb_initiator.sv
// APB4 initiator for the GPIO controller slave port: one command in, one APB transfer,
// one response out. Adds an ACCESS-phase timeout and local rejection of unaligned addresses.
module gpio_ctrl_apb_initiator #(
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [3:0]        cmd_strb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] paddr,
   output logic              pwrite,
   output logic              psel,
   output logic              penable,
   output logic [3:0]        pstrb,
   output logic [31:0]       pwdata,
   input  logic [31:0]       prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             timeout_hit_c;

   // Abort at the end of the ACCESS cycle in which the wait count would reach the limit.
   assign timeout_hit_c = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         paddr       <= '0;
         pwrite      <= 1'b0;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pstrb       <= '0;
         pwdata      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  if (cmd_addr[1:0] != 2'b00) begin
                     state       <= RESP;
                     rsp_valid   <= 1'b1;
                     rsp_err     <= 1'b1;
                     rsp_timeout <= 1'b0;
                     rsp_rdata   <= '0;
                  end else begin
                     state   <= SETUP;
                     cnt     <= '0;
                     psel    <= 1'b1;
                     penable <= 1'b0;
                     paddr   <= cmd_addr;
                     pwrite  <= cmd_write;
                     pwdata  <= cmd_wdata;
                     pstrb   <= cmd_write ? cmd_strb : 4'h0;
                  end
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= pslverr;
                  rsp_timeout <= 1'b0;
                  rsp_rdata   <= (!pwrite && !pslverr) ? prdata : 32'h0;
                  state       <= RESP;
               end else if (timeout_hit_c) begin
                  psel        <= 1'b0;
                  penable     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= '0;
                  state       <= RESP;
               end else if (TIMEOUT_CYCLES != 0) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_ctrl_apb_initiator.sv
// Directed vector bench for gpio_ctrl_apb_initiator with a small reactive APB slave model.
module tb_gpio_ctrl_apb_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [9:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic [9:0]  paddr;
   logic        pwrite, psel, penable;
   logic [3:0]  pstrb;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr;

   int total = 0;
   int passed = 0;

   always #5 clk = ~clk;

   gpio_ctrl_apb_initiator #(.ADDR_W(10), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
      .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   // waits: ACCESS wait cycles before pready (-1 = never); hold: cycles rsp_ready stays low
   typedef struct {
      logic        write;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      int          hold;
      logic        exp_err;
      logic        exp_to;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      bit        unal;
      int        n, acc, exp_lat, exp_acc;
      bit        saw_psel, req_ok;
      logic [3:0] exp_strb;
      logic [31:0] r_data;
      logic        r_err, r_to;
      bit          stable;

      unal     = (v.addr[1:0] != 2'b00);
      exp_strb = v.write ? v.strb : 4'h0;
      exp_acc  = unal ? 0 : (v.waits < 0 ? 16 : v.waits + 1);
      exp_lat  = unal ? 1 : (v.waits < 0 ? 18 : 3 + v.waits);

      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_strb  = v.strb;
      tick();
      cmd_valid = 1'b0;

      n = 1; acc = 0; saw_psel = 0; req_ok = 1;
      while (!rsp_valid && n < 100) begin
         pready  = 1'b0;
         pslverr = 1'b0;
         prdata  = 32'h0;
         if (psel) begin
            saw_psel = 1;
            if (paddr !== v.addr || pwrite !== v.write || pwdata !== v.wdata || pstrb !== exp_strb)
               req_ok = 0;
         end
         if (cmd_ready) req_ok = 0;
         if (psel && penable) begin
            acc++;
            if (v.waits >= 0 && acc > v.waits) begin
               pready  = 1'b1;
               pslverr = v.slverr;
               prdata  = v.prdata;
            end
         end
         tick();
         n++;
      end
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;

      chk("rsp_latency", 32'(n), 32'(exp_lat));
      chk("access_cycles", 32'(acc), 32'(exp_acc));
      chk("apb_activity", 32'(saw_psel), 32'(!unal));
      chk("apb_request_fields", 32'(req_ok), 32'd1);
      chk("psel_after_done", 32'(psel | penable), 32'd0);
      chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
      chk("rsp_rdata", rsp_rdata, v.exp_rdata);

      r_data = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
      stable = 1;
      for (int i = 0; i < v.hold; i++) begin
         tick();
         if (!rsp_valid || cmd_ready || rsp_rdata !== r_data || rsp_err !== r_err ||
             rsp_timeout !== r_to || psel)
            stable = 0;
      end
      chk("rsp_hold_stable", 32'(stable), 32'd1);

      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      vecs[0] = '{1'b1, 10'h004, 32'hA5A5_0F0F, 4'hF,  0, 32'h0,        1'b0, 0, 1'b0, 1'b0, 32'h0};
      vecs[1] = '{1'b0, 10'h010, 32'h0,        4'hF,  3, 32'h1234_5678, 1'b0, 0, 1'b0, 1'b0, 32'h1234_5678};
      vecs[2] = '{1'b0, 10'h020, 32'h0,        4'h0, -1, 32'hFFFF_FFFF, 1'b0, 1, 1'b1, 1'b1, 32'h0};
      vecs[3] = '{1'b1, 10'h006, 32'h1111_2222, 4'hF, 0, 32'h0,        1'b0, 0, 1'b1, 1'b0, 32'h0};
      vecs[4] = '{1'b0, 10'h030, 32'h0,        4'h0,  0, 32'hDEAD_BEEF, 1'b1, 5, 1'b1, 1'b0, 32'h0};
      vecs[5] = '{1'b1, 10'h3FC, 32'h0BAD_F00D, 4'h5, 1, 32'h0000_FFFF, 1'b0, 2, 1'b0, 1'b0, 32'h0};
      vecs[6] = '{1'b0, 10'h001, 32'h0,        4'h0,  0, 32'h0,        1'b0, 2, 1'b1, 1'b0, 32'h0};
      vecs[7] = '{1'b0, 10'h008, 32'h0,        4'h0, 15, 32'hCAFE_0008, 1'b0, 0, 1'b0, 1'b0, 32'hCAFE_0008};

      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_strb = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
      tick(); tick();
      chk("reset_psel_penable", 32'(psel | penable | pwrite), 32'd0);
      chk("reset_apb_bus", {paddr, pstrb} | 14'(pwdata), 32'd0);
      chk("reset_rsp", {rsp_rdata[30:0], rsp_valid} | 32'(rsp_err | rsp_timeout | rsp_rdata[31]), 32'd0);
      chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset in the middle of an ACCESS phase that never completes
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h040;
      tick();
      cmd_valid = 1'b0;
      tick(); tick(); tick();
      chk("rst_pre_access", 32'({psel, penable}), 32'd3);
      rst = 1'b1;
      #1;
      chk("rst_drop_psel", 32'({psel, penable}), 32'd0);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
      rst = 1'b0;
      ok = 1;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (rsp_valid || psel || !cmd_ready) ok = 0;
      end
      chk("rst_quiet_after", 32'(ok), 32'd1);
      run_vec(vecs[0]);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
